// File: rtl/dll_tx_sequencer.sv
// dll_tx_sequencer: sequences LFSR start, CRC append and replay hand-off per TLP,
// tracking the unacknowledged replay window and stalling intake when it is full.
module dll_tx_sequencer #(
  parameter int MAX_OUTSTANDING = 16,
  parameter int LFSR_TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tlp_valid,
  input  logic [95:0]  tlp_data,
  output logic         tlp_ready,
  output logic         lfsr_start,
  output logic [127:0] lfsr_data,
  input  logic         lfsr_done,
  input  logic [15:0]  lfsr_crc,
  output logic         crc_rdy,
  output logic [127:0] crc_data,
  output logic [15:0]  crc_lfsr,
  input  logic [127:0] crc_frame,
  output logic         frm_valid,
  output logic [127:0] frm_data,
  input  logic         frm_ready,
  input  logic         ack_valid,
  input  logic [11:0]  ack_seq,
  output logic [11:0]  next_seq,
  output logic [11:0]  outstanding,
  output logic         lfsr_err
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, APPEND = 2'd2, OUTPUT = 2'd3;
  localparam int TW = $clog2(LFSR_TIMEOUT + 1);
  logic [1:0] state;
  logic [TW-1:0] timer;
  logic [127:0] frame, frm_q;
  logic [15:0] crc_q;
  logic [11:0] acked_seq, d;
  logic ack_ok, push, done;
  // modulo-4096 distance makes stale, duplicate and wrapped ACKs fall out of range naturally
  assign d = ack_seq - acked_seq;
  assign ack_ok = ack_valid && d != 12'd0 && d <= outstanding;
  assign tlp_ready = state == IDLE && outstanding < 12'(MAX_OUTSTANDING);
  assign push = state == OUTPUT && frm_ready;
  // timer is zero only in the start cycle, so a done there is ignored
  assign done = state == RUN && timer != '0 && lfsr_done;
  assign lfsr_start = state == RUN && timer == '0;
  assign lfsr_data = state == RUN ? frame : '0;
  assign crc_rdy = state == APPEND;
  assign crc_data = crc_rdy ? frame : '0;
  assign crc_lfsr = crc_rdy ? crc_q : '0;
  assign frm_valid = state == OUTPUT;
  assign frm_data = frm_valid ? frm_q : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      timer <= '0;
      frame <= '0;
      frm_q <= '0;
      crc_q <= '0;
      next_seq <= '0;
      acked_seq <= 12'hFFF;
      outstanding <= '0;
      lfsr_err <= 1'b0;
    end else begin
      if (ack_ok) acked_seq <= ack_seq;
      outstanding <= outstanding + 12'(push) - (ack_ok ? d : 12'd0);
      if (push) next_seq <= next_seq + 12'd1;
      case (state)
        IDLE: if (tlp_valid && tlp_ready) begin
          frame <= {4'h0, next_seq, tlp_data, 16'h0000};
          timer <= '0;
          state <= RUN;
        end
        RUN: if (done) begin
          crc_q <= lfsr_crc;
          state <= APPEND;
        end else if (timer == TW'(LFSR_TIMEOUT - 1)) begin
          lfsr_err <= 1'b1;
          state <= IDLE;
        end else begin
          timer <= timer + 1'b1;
        end
        APPEND: begin
          frm_q <= crc_frame;
          state <= OUTPUT;
        end
        default: if (frm_ready) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dll_tx_sequencer.sv
// tb_dll_tx_sequencer: directed frames against a sequence-pointer model of the
// replay window, checked every cycle plus literal spot checks.
module tb_dll_tx_sequencer;
  logic clk = 0, rst_n = 0;
  logic tlp_valid = 0, lfsr_done = 0, frm_ready = 0, ack_valid = 0;
  logic [95:0] tlp_data = '0;
  logic [15:0] lfsr_crc = '0, crc_lfsr;
  logic [11:0] ack_seq = '0, next_seq, outstanding;
  logic tlp_ready, lfsr_start, crc_rdy, frm_valid, lfsr_err;
  logic [127:0] lfsr_data, crc_data, crc_frame, frm_data, last_frm;
  logic [11:0] m_next = 12'h000, m_acked = 12'hFFF, m_out;
  logic push_now = 0;
  int n_chk = 0, n_fail = 0;

  dll_tx_sequencer dut (
    .clk(clk), .rst_n(rst_n), .tlp_valid(tlp_valid), .tlp_data(tlp_data),
    .tlp_ready(tlp_ready), .lfsr_start(lfsr_start), .lfsr_data(lfsr_data),
    .lfsr_done(lfsr_done), .lfsr_crc(lfsr_crc), .crc_rdy(crc_rdy),
    .crc_data(crc_data), .crc_lfsr(crc_lfsr), .crc_frame(crc_frame),
    .frm_valid(frm_valid), .frm_data(frm_data), .frm_ready(frm_ready),
    .ack_valid(ack_valid), .ack_seq(ack_seq), .next_seq(next_seq),
    .outstanding(outstanding), .lfsr_err(lfsr_err)
  );

  always #5 clk = ~clk;
  // ideal CRC stage: drop the captured CRC into the low 16 bits
  assign crc_frame = {crc_data[127:16], crc_lfsr};
  assign m_out = m_next - m_acked - 12'd1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // window model kept as two sequence pointers
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_next = 12'h000;
      m_acked = 12'hFFF;
    end else begin
      if (ack_valid && (ack_seq - m_acked) != 12'd0 && (ack_seq - m_acked) <= m_out) m_acked = ack_seq;
      if (push_now) m_next = m_next + 12'd1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("next_seq", next_seq, m_next);
      chk("outstanding", outstanding, m_out);
    end
  end

  task automatic ack(input logic [11:0] s);
    @(negedge clk);
    ack_valid = 1;
    ack_seq = s;
    @(posedge clk);
    #1 ack_valid = 0;
  endtask

  task automatic send(input logic [95:0] tlp, input logic [15:0] crc, input int dly,
                      input int bp, input int rst_at, input bit early,
                      input bit do_ack, input logic [11:0] aseq);
    logic [127:0] fr, ef;
    int n, lim;
    @(negedge clk);
    tlp_valid = 1;
    tlp_data = tlp;
    lfsr_crc = crc;
    n = 0;
    while (!tlp_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!tlp_ready) begin
      chk("accept_wait", 0, 1);
      tlp_valid = 0;
      return;
    end
    fr = {4'h0, m_next, tlp, 16'h0000};
    ef = {fr[127:16], crc};
    @(negedge clk);
    tlp_valid = 0;
    chk("lfsr_start", lfsr_start, 1);
    chk("lfsr_data", lfsr_data, fr);
    lfsr_done = early;
    lim = dly < 0 ? 64 : dly + 1;
    for (int k = 2; k <= lim; k++) begin
      @(negedge clk);
      lfsr_done = dly >= 0 && k == dly + 1;
      chk("lfsr_start_once", lfsr_start, 0);
      chk("crc_rdy_wait", crc_rdy, 0);
      chk("lfsr_data_hold", lfsr_data, fr);
      if (dly < 0 && k == 64) chk("err_before_timeout", lfsr_err, 0);
    end
    @(negedge clk);
    lfsr_done = 0;
    if (dly < 0) begin
      chk("lfsr_err", lfsr_err, 1);
      chk("timeout_frm_valid", frm_valid, 0);
      chk("timeout_idle", tlp_ready, 1);
      return;
    end
    chk("crc_rdy", crc_rdy, 1);
    chk("crc_lfsr", crc_lfsr, crc);
    chk("crc_data", crc_data, fr);
    chk("append_frm_valid", frm_valid, 0);
    @(negedge clk);
    chk("crc_rdy_single", crc_rdy, 0);
    chk("frm_valid", frm_valid, 1);
    chk("frm_data", frm_data, ef);
    last_frm = frm_data;
    for (int b = 1; b <= bp; b++) begin
      if (b == rst_at) begin
        #2 rst_n = 0;
        #1;
        chk("rst_frm_valid", frm_valid, 0);
        chk("rst_next_seq", next_seq, 0);
        chk("rst_outstanding", outstanding, 0);
        return;
      end
      @(negedge clk);
      chk("bp_frm_valid", frm_valid, 1);
      chk("bp_frm_data", frm_data, ef);
      chk("bp_tlp_ready", tlp_ready, 0);
    end
    frm_ready = 1;
    push_now = 1;
    if (do_ack) begin
      ack_valid = 1;
      ack_seq = aseq;
    end
    @(posedge clk);
    #1;
    frm_ready = 0;
    push_now = 0;
    ack_valid = 0;
    @(negedge clk);
    chk("frm_valid_drop", frm_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [11:0] mo;
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("reset_next_seq", next_seq, 12'h000);
    chk("reset_outstanding", outstanding, 12'h000);
    chk("reset_lfsr_err", lfsr_err, 0);
    chk("reset_tlp_ready", tlp_ready, 1);
    chk("reset_frm_valid", frm_valid, 0);
    chk("reset_crc_rdy", crc_rdy, 0);
    chk("reset_lfsr_start", lfsr_start, 0);
    // basic frame
    send(96'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF, 16'hBEEF, 3, 0, 0, 0, 0, 0);
    chk("basic_frame", last_frm, 128'h0000_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_BEEF);
    chk("basic_next_seq", next_seq, 12'd1);
    chk("basic_outstanding", outstanding, 12'd1);
    // window full
    @(negedge clk) rst_n = 0;
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < 16; i++) send({32'h1000 + 32'(i), 64'hFEED_0000_0000_0000}, 16'(i), 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("full_outstanding", outstanding, 12'd16);
    chk("full_tlp_ready", tlp_ready, 0);
    ack(12'h003);
    @(negedge clk);
    chk("ack3_outstanding", outstanding, 12'd12);
    chk("ack3_tlp_ready", tlp_ready, 1);
    ack(12'h001);
    @(negedge clk);
    chk("stale_ack_outstanding", outstanding, 12'd12);
    // simultaneous push and ACK
    ack(12'd10);
    @(negedge clk);
    chk("pre_sim_outstanding", outstanding, 12'd5);
    send(96'h1234_5678_9ABC_DEF0_1357_9BDF, 16'h55AA, 1, 0, 0, 0, 1, 12'd12);
    chk("sim_outstanding", outstanding, 12'd4);
    // wrap
    @(negedge clk) rst_n = 0;
    @(negedge clk) rst_n = 1;
    for (int i = 0; i <= 4096; i++) begin
      send({3{32'(i)}}, 16'(i), 1, 0, 0, 0, 0, 0);
      if (i == 4095) chk("wrap_seq_fff", last_frm[123:112], 12'hFFF);
      if (i == 4096) chk("wrap_seq_000", last_frm[123:112], 12'h000);
      mo = m_next - m_acked - 12'd1;
      if (mo >= 12'd8) ack(m_next - 12'd1);
    end
    @(negedge clk);
    chk("wrap_next_seq", next_seq, 12'd1);
    // LFSR timeout, then reuse of the same sequence number
    send(96'hDEAD_DEAD_DEAD_DEAD_DEAD_DEAD, 16'h0BAD, -1, 0, 0, 0, 0, 0);
    chk("timeout_next_seq", next_seq, 12'd1);
    send(96'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F, 16'hC0DE, 2, 0, 0, 0, 0, 0);
    chk("reuse_seq", last_frm[123:112], 12'd1);
    send(96'h7777_6666_5555_4444_3333_2222, 16'h1111, 63, 0, 0, 0, 0, 0);
    send(96'h8888_9999_AAAA_BBBB_CCCC_DDDD, 16'h2222, 1, 0, 0, 1, 0, 0);
    // backpressure, then reset during backpressure
    send(96'hCAFE_F00D_CAFE_F00D_CAFE_F00D, 16'h3333, 1, 10, 0, 0, 0, 0);
    send(96'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0, 16'h4444, 1, 10, 5, 0, 0, 0);
    @(negedge clk);
    chk("held_reset_frm_valid", frm_valid, 0);
    rst_n = 1;
    @(negedge clk);
    chk("post_reset_lfsr_err", lfsr_err, 0);
    send(96'h0123_4567_89AB_CDEF_0123_4567, 16'h5555, 1, 0, 0, 0, 0, 0);
    chk("post_reset_seq", last_frm[123:112], 12'h000);
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
